// File: rtl/tow_pkg.sv
// Shared types and defaults for the tug-of-war match sequencer.
package tow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    ROUND_OVER,
    MATCH_OVER
  } state_t;

  localparam int DEF_WINS_TO_MATCH = 3;
  localparam int DEF_COUNT_START   = 3;
  localparam int DEF_HOLD_TICKS    = 8;
  localparam int DEF_SCORE_W       = 3;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one registered copy of the level, pulse while level is newly high.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/tow_match_controller.sv
// Round/match sequencer for the tug-of-war playfield: countdown, play, result hold,
// best-of scoring, and arbitration of button presses into single-cycle move pulses.
module tow_match_controller
  import tow_pkg::*;
#(
  parameter int WINS_TO_MATCH = DEF_WINS_TO_MATCH,
  parameter int COUNT_START   = DEF_COUNT_START,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int SCORE_W       = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               start,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               win_l,
  input  logic               win_r,
  output logic               move_l,
  output logic               move_r,
  output logic               field_clear,
  output logic               play_en,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_done,
  output logic               match_winner
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [1:0]         COUNT_INIT = 2'(COUNT_START);
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(WINS_TO_MATCH);

  if (WINS_TO_MATCH < 1 || WINS_TO_MATCH > (2 ** SCORE_W) - 1) begin : g_bad_wins
    $error("WINS_TO_MATCH must be 1..2**SCORE_W-1");
  end
  if (COUNT_START < 1 || COUNT_START > 3) begin : g_bad_count
    $error("COUNT_START must be 1..3");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("HOLD_TICKS must be at least 1");
  end

  // Bit order: 0 = start, 1 = left button, 2 = right button.
  logic [2:0] levels;
  logic [2:0] presses;
  logic       start_press, press_l, press_r;

  assign levels = {btn_r, btn_l, start};

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    edge_pulse u_edge (
      .clk   (clk),
      .reset (reset),
      .level (levels[gi]),
      .pulse (presses[gi])
    );
  end

  assign start_press = presses[0];
  assign press_l     = presses[1];
  assign press_r     = presses[2];

  state_t            state_reg;
  logic [HOLD_W-1:0] hold_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      move_l       <= 1'b0;
      move_r       <= 1'b0;
      field_clear  <= 1'b0;
      play_en      <= 1'b0;
      countdown    <= 2'd0;
      score_l      <= '0;
      score_r      <= '0;
      match_done   <= 1'b0;
      match_winner <= LEFT;
    end else begin
      move_l      <= 1'b0;
      move_r      <= 1'b0;
      field_clear <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_press) begin
            field_clear <= 1'b1;
            countdown   <= COUNT_INIT;
            state_reg   <= COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (ce) begin
            if (countdown == 2'd1) begin
              countdown <= 2'd0;
              play_en   <= 1'b1;
              state_reg <= PLAY;
            end else begin
              countdown <= countdown - 2'd1;
            end
          end
        end
        PLAY: begin
          // A win sampled this clk ends the round and suppresses any move.
          if (win_l || win_r) begin
            play_en   <= 1'b0;
            hold_reg  <= '0;
            state_reg <= ROUND_OVER;
            if (win_l && !win_r) score_l <= score_l + SCORE_W'(1);
            if (win_r && !win_l) score_r <= score_r + SCORE_W'(1);
          end else if (press_l ^ press_r) begin
            move_l <= press_l;
            move_r <= press_r;
          end
        end
        ROUND_OVER: begin
          if (ce) begin
            if (hold_reg == HOLD_LAST) begin
              if (score_l == WIN_SCORE) begin
                match_done   <= 1'b1;
                match_winner <= LEFT;
                state_reg    <= MATCH_OVER;
              end else if (score_r == WIN_SCORE) begin
                match_done   <= 1'b1;
                match_winner <= RIGHT;
                state_reg    <= MATCH_OVER;
              end else begin
                field_clear <= 1'b1;
                countdown   <= COUNT_INIT;
                state_reg   <= COUNTDOWN;
              end
            end else begin
              hold_reg <= hold_reg + HOLD_W'(1);
            end
          end
        end
        MATCH_OVER: begin
          if (start_press) begin
            score_l     <= '0;
            score_r     <= '0;
            match_done  <= 1'b0;
            field_clear <= 1'b1;
            countdown   <= COUNT_INIT;
            state_reg   <= COUNTDOWN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tow_match_controller.sv
// Randomized scoreboard bench: a behavioural match model predicts every clk's outputs.
module tb_tow_match_controller;

  localparam int WINS = 3;
  localparam int CS   = 3;
  localparam int HOLD = 8;
  localparam int SW   = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0, start = 1'b0, btn_l = 1'b0, btn_r = 1'b0, win_l = 1'b0, win_r = 1'b0;
  logic move_l, move_r, field_clear, play_en, match_done, match_winner;
  logic [1:0] countdown;
  logic [SW-1:0] score_l, score_r;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tow_match_controller #(
    .WINS_TO_MATCH (WINS),
    .COUNT_START   (CS),
    .HOLD_TICKS    (HOLD),
    .SCORE_W       (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .start        (start),
    .btn_l        (btn_l),
    .btn_r        (btn_r),
    .win_l        (win_l),
    .win_r        (win_r),
    .move_l       (move_l),
    .move_r       (move_r),
    .field_clear  (field_clear),
    .play_en      (play_en),
    .countdown    (countdown),
    .score_l      (score_l),
    .score_r      (score_r),
    .match_done   (match_done),
    .match_winner (match_winner)
  );

  typedef struct {
    logic       ml, mr, fc, pe, md, mw;
    logic [1:0] cd;
    int         sl, sr;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model: the match phase is a name, counters are plain ints.
  string ph;
  int    cnt, hold, sl, sr;
  bit    winner, l_q, r_q, s_q;

  task automatic model_reset();
    ph = "IDLE"; cnt = 0; hold = 0; sl = 0; sr = 0;
    winner = 0; l_q = 0; r_q = 0; s_q = 0;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge reset);
    model_reset();
    exp_q.delete();
  end

  initial begin
    model_reset();
    forever begin
      exp_t e;
      bit pl, pr, ps, fc, ml, mr;
      @(posedge clk);
      if (reset) begin
        model_reset();
        fc = 0; ml = 0; mr = 0;
      end else begin
        pl = btn_l && !l_q; pr = btn_r && !r_q; ps = start && !s_q;
        l_q = btn_l; r_q = btn_r; s_q = start;
        fc = 0; ml = 0; mr = 0;
        if (ph == "IDLE") begin
          if (ps) begin fc = 1; cnt = CS; ph = "COUNTDOWN"; end
        end else if (ph == "COUNTDOWN") begin
          if (ce) begin
            if (cnt == 1) ph = "PLAY";
            else cnt--;
          end
        end else if (ph == "PLAY") begin
          if (win_l || win_r) begin
            if (win_l && !win_r) sl++;
            if (win_r && !win_l) sr++;
            hold = 0; ph = "ROUND_OVER";
          end else if (pl != pr) begin
            ml = pl; mr = pr;
          end
        end else if (ph == "ROUND_OVER") begin
          if (ce) begin
            hold++;
            if (hold == HOLD) begin
              if (sl == WINS)      begin winner = 0; ph = "MATCH_OVER"; end
              else if (sr == WINS) begin winner = 1; ph = "MATCH_OVER"; end
              else begin fc = 1; cnt = CS; ph = "COUNTDOWN"; end
            end
          end
        end else begin
          if (ps) begin sl = 0; sr = 0; fc = 1; cnt = CS; ph = "COUNTDOWN"; end
        end
      end
      e.ml = ml; e.mr = mr; e.fc = fc;
      e.pe = (ph == "PLAY");
      e.cd = (ph == "COUNTDOWN") ? 2'(cnt) : 2'd0;
      e.md = (ph == "MATCH_OVER");
      e.mw = winner;
      e.sl = sl; e.sr = sr;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expectation consumed per falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (reset) begin
          check("async_reset_outputs",
                {move_l, move_r, field_clear, play_en, countdown, match_done, match_winner}, 8'd0);
          check("async_reset_scores", {2'b0, score_l, score_r}, 8'd0);
        end else begin
          tests++;
          failed++;
          $display("FAIL no_expectation: got output with empty scoreboard at %0t", $time);
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("move_l", {7'd0, move_l}, {7'd0, e.ml});
        check("move_r", {7'd0, move_r}, {7'd0, e.mr});
        check("field_clear", {7'd0, field_clear}, {7'd0, e.fc});
        check("play_en", {7'd0, play_en}, {7'd0, e.pe});
        check("countdown", {6'd0, countdown}, {6'd0, e.cd});
        check("score_l", {5'd0, score_l}, 8'(e.sl));
        check("score_r", {5'd0, score_r}, 8'(e.sr));
        check("match_done", {7'd0, match_done}, {7'd0, e.md});
        if (e.md) check("match_winner", {7'd0, match_winner}, {7'd0, e.mw});
        if (e.ml || e.mr || e.fc || (e.md && !e.pe && e.cd == 0 && e.fc))
          $display("[TB] t=%0t move_l=%0b move_r=%0b field_clear=%0b score=%0d/%0d",
                   $time, move_l, move_r, field_clear, score_l, score_r);
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3000) begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
      ce = ($urandom_range(0, 2) == 0) && ((cyc % 500) >= 40);
      if ($urandom_range(0, 9) == 0) btn_l = ~btn_l;
      if ($urandom_range(0, 9) == 0) btn_r = ~btn_r;
      if (!btn_l && !btn_r && $urandom_range(0, 15) == 0) begin
        btn_l = 1'b1;
        btn_r = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) start = ~start;
      win_l = 1'b0;
      win_r = 1'b0;
      if (play_en && $urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 5))
          0:       begin win_l = 1'b1; win_r = 1'b1; end
          1, 2:    win_l = 1'b1;
          default: win_r = 1'b1;
        endcase
      end else if ($urandom_range(0, 60) == 0) begin
        win_l = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tow_match_controller.md
Name: tow_match_controller

Overview:
Match sequencer for the tug-of-war playfield. It runs each round as countdown, play and result hold, and keeps a best-of match score. It converts the two players' button levels into arbitrated single-cycle move pulses. It sits between the key/switch inputs and the playfield, and paces itself with the divided clock-enable tick.

Parameters:
WINS_TO_MATCH, 3, round wins needed to take the match; must be <= 2**SCORE_W-1 (elaboration assertion)
COUNT_START, 3, countdown start value in ce ticks; range 1..3
HOLD_TICKS, 8, ce ticks the round result is held before the next round
SCORE_W, 3, width of each score counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ce  in  1  one-clk tick enable from the clock divider
start  in  1  start/restart level, rising-edge detected
btn_l  in  1  left player button level, active high, already synchronized
btn_r  in  1  right player button level, active high, already synchronized
win_l  in  1  playfield reports light reached left end
win_r  in  1  playfield reports light reached right end
move_l  out  1  one-clk pulse: pull light left
move_r  out  1  one-clk pulse: pull light right
field_clear  out  1  one-clk pulse: recentre playfield
play_en  out  1  high only in PLAY
countdown  out  2  countdown digit for display; 0 outside COUNTDOWN
score_l  out  SCORE_W  left round wins
score_r  out  SCORE_W  right round wins
match_done  out  1  high in MATCH_OVER
match_winner  out  1  0 = left, 1 = right; valid while match_done

Behaviour:
- Reset, async and any time: state IDLE, all outputs 0, scores 0, edge registers 0, counters 0. Reset mid-round abandons the round with no score change.
- Edge detect: press_x = btn_x & ~btn_x_q, sampled every clk, not gated by ce. Same for start. A held button yields exactly one press.
- Arbitration:
  - In PLAY, with neither win_l nor win_r high, a press_l alone gives move_l on the next clk; press_r alone gives move_r. Latency is 1 clk.
  - press_l and press_r in the same clk cancel; no pulse is issued.
  - Presses in any other state are discarded and never queued.
- IDLE: rising start -> field_clear pulse, count=COUNT_START, go to COUNTDOWN.
- COUNTDOWN:
  - countdown output = count.
  - On each ce: if count==1, go to PLAY with countdown=0; else count decrements.
- PLAY:
  - play_en=1.
  - win_l only -> score_l+1, go to ROUND_OVER. win_r only -> score_r+1, go to ROUND_OVER.
  - Both high in the same clk -> ROUND_OVER with no score change (replay round).
  - No move pulse is issued in the clk a win is sampled.
- ROUND_OVER:
  - play_en=0. A hold counter counts ce ticks from 0.
  - When HOLD_TICKS ticks have elapsed:
    - a score == WINS_TO_MATCH -> MATCH_OVER, match_winner latched;
    - else field_clear pulse, count=COUNT_START, go to COUNTDOWN.
- MATCH_OVER:
  - match_done=1; scores and winner are held.
  - Rising start -> scores cleared, field_clear pulse, go to COUNTDOWN. match_done drops the same clk.
- start edges outside IDLE and MATCH_OVER are ignored. Scores never wrap; the assertion guarantees this.
- All outputs are registered. field_clear, move_l and move_r are never high for more than 1 clk per event.

Decomposition:
- Package tow_pkg holds:
  - the state enum (IDLE, COUNTDOWN, PLAY, ROUND_OVER, MATCH_OVER);
  - default constants for WINS_TO_MATCH, COUNT_START and HOLD_TICKS;
  - the player index encoding (LEFT=0, RIGHT=1).
- One sub-module, edge_pulse: a registered rising-edge detector, instantiated for start, btn_l and btn_r.

Test Plan:
- Reset and start: reset high mid-PLAY -> all outputs 0 asynchronously; release, start edge -> field_clear one clk, countdown 3,2,1 on successive ce, then play_en=1 on the ce after countdown=1.
- Arbitration: in PLAY, btn_l held 10 clk -> exactly one move_l, 1 clk after the edge; btn_l and btn_r rising in the same clk -> no move pulse; press during COUNTDOWN -> no pulse.
- Round scoring: win_r one clk in PLAY -> score_r=1, play_en=0; after 8 ce ticks field_clear pulses and countdown restarts at 3.
- Tie: win_l and win_r together -> scores unchanged, round replays after hold.
- Match end: left wins 3 rounds with right on 2 -> match_done=1, match_winner=0, scores 3/2 held; start edge -> scores 0/0, field_clear, countdown 3.
- Noise immunity: ce held low in COUNTDOWN -> state frozen, countdown stays; start toggled in PLAY -> no effect.
